// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types and constants for the DAC sample path
package dac_pkg;

   // Default sample width shared with the sigma-delta DAC top
   localparam int DAC_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } feeder_state_t;

   // Offset-binary zero (DC centre) for a sample of the given width
   function automatic logic [31:0] midscale(input int width);
      return 32'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// rtl/dac_sample_fifo.sv - first-word-fall-through register FIFO for DAC samples
module dac_sample_fifo
   import dac_pkg::*;
#(
   parameter int DATA_W = DAC_DATA_W,
   parameter int DEPTH  = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata,
   output logic [AW:0]       level,
   output logic              full,
   output logic              empty
);

   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push_en;
   logic              pop_en;

   // A push while full is refused even if a pop happens in the same cycle
   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Sample storage; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap modulo DEPTH; level tracks push minus pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_en, pop_en})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/dac_sample_feeder.sv
// rtl/dac_sample_feeder.sv - rate-paced sample buffer feeding the DAC (option: DAC_FEEDER_MIDSCALE_EN)
module dac_sample_feeder
   import dac_pkg::*;
#(
   parameter int DATA_W      = DAC_DATA_W,
   parameter int DEPTH       = 16,
   parameter int RATE_DIV    = 64,
   parameter int PRIME_LEVEL = 8,
   localparam int LW         = $clog2(DEPTH) + 1,
   localparam int CW         = $clog2(RATE_DIV)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_strobe,
   output logic [LW-1:0]     level,
   output logic              underflow,
   input  logic              clear_underflow
);

   localparam logic [DATA_W-1:0] MIDSCALE  = DATA_W'(midscale(DATA_W));
   localparam logic [CW-1:0]     TICK_CNT  = CW'(RATE_DIV - 1);
   localparam logic [LW-1:0]     PRIME_LVL = LW'(PRIME_LEVEL);
`ifdef DAC_FEEDER_MIDSCALE_EN
   localparam logic [DATA_W-1:0] RST_SAMPLE = MIDSCALE;
`else
   localparam logic [DATA_W-1:0] RST_SAMPLE = '0;
`endif

   feeder_state_t     state;
   logic [CW-1:0]     pacer;
   logic              ready_armed;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic [DATA_W-1:0] fifo_head;
   logic              tick;

   // A tick needs enable too, so a disable on the tick cycle never strobes in IDLE
   assign tick     = (state == ST_RUN) && enable && (pacer == TICK_CNT);
   assign fifo_pop = tick && !fifo_empty;
   // ready_armed keeps in_ready low until the first clock after reset release
   assign in_ready = ready_armed && !fifo_full;

   dac_sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_valid && ready_armed),
      .wdata (in_data),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Pacer, state machine and registered DAC-side outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         pacer         <= '0;
         sample_out    <= RST_SAMPLE;
         sample_strobe <= 1'b0;
         underflow     <= 1'b0;
         ready_armed   <= 1'b0;
      end else begin
         ready_armed   <= 1'b1;
         sample_strobe <= tick;

         if (tick) begin
            if (!fifo_empty) begin
               sample_out <= fifo_head;
            end else begin
`ifdef DAC_FEEDER_MIDSCALE_EN
               sample_out <= MIDSCALE;
`else
               sample_out <= sample_out;
`endif
            end
         end

         // A fresh underflow outranks a coincident clear
         if (tick && fifo_empty)   underflow <= 1'b1;
         else if (clear_underflow) underflow <= 1'b0;

         case (state)
            ST_IDLE: begin
               pacer <= '0;
               if (enable) state <= ST_PRIME;
            end
            ST_PRIME: begin
               pacer <= '0;
               if (!enable)                 state <= ST_IDLE;
               else if (level >= PRIME_LVL) state <= ST_RUN;
            end
            ST_RUN: begin
               if (!enable) begin
                  state <= ST_IDLE;
                  pacer <= '0;
`ifdef DAC_FEEDER_MIDSCALE_EN
                  sample_out <= MIDSCALE;
`endif
               end else begin
                  pacer <= (pacer == TICK_CNT) ? '0 : pacer + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               pacer <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb/tb_dac_sample_feeder.sv - randomized scoreboard bench for dac_sample_feeder
module tb_dac_sample_feeder;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int RD    = 4;
   localparam int PL    = 8;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef DAC_FEEDER_MIDSCALE_EN
   localparam bit MID_EN = 1'b1;
`else
   localparam bit MID_EN = 1'b0;
`endif
   localparam int MID     = 128;
   localparam int RST_VAL = MID_EN ? MID : 0;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] sample_out;
   logic          sample_strobe;
   logic [LW-1:0] level;
   logic          underflow;
   logic          clear_underflow = 1'b0;

   int tests = 0;
   int fails = 0;

   // reference model: sample queue plus simple run-state bookkeeping
   int mq[$];
   int expq[$];
   int mstate = 0;
   int mcnt = 0;
   int msample = RST_VAL;
   bit munder = 0;
   bit mstrobe = 0;
   bit marmed = 0;

   always #5 clk = ~clk;

   dac_sample_feeder #(
      .DATA_W(DW), .DEPTH(DEPTH), .RATE_DIV(RD), .PRIME_LEVEL(PL)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .sample_out(sample_out),
      .sample_strobe(sample_strobe), .level(level), .underflow(underflow),
      .clear_underflow(clear_underflow)
   );

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every strobe must match the oldest outstanding expected sample
   always @(posedge clk) begin
      #1;
      if (sample_strobe === 1'b1) begin
         tests++;
         if (expq.size() == 0) begin
            fails++;
            $display("FAIL strobe_unexpected: got value %0d expected no strobe", sample_out);
         end else begin
            int e;
            e = expq.pop_front();
            if (int'(sample_out) != e) begin
               fails++;
               $display("FAIL strobe_value: got %0d expected %0d", sample_out, e);
            end
         end
      end
   end

   // advance the model by one clock given the inputs about to be sampled
   task automatic model_step(input bit r, input bit en, input bit v, input int d, input bit clr);
      int  lvl;
      bit  tk;
      bit  acc;
      int  old_state;
      if (!r) begin
         mq.delete();
         mstate = 0; mcnt = 0; munder = 0; msample = RST_VAL; mstrobe = 0; marmed = 0;
         return;
      end
      lvl = mq.size();
      old_state = mstate;
      acc = v && marmed && (lvl != DEPTH);
      tk = (mstate == 2) && en && (mcnt == RD - 1);
      mstrobe = tk;
      if (tk) begin
         if (lvl > 0) msample = mq.pop_front();
         else if (MID_EN) msample = MID;
         expq.push_back(msample);
      end
      if (tk && lvl == 0) munder = 1;
      else if (clr) munder = 0;
      if (acc) mq.push_back(d);
      case (mstate)
         0: if (en) mstate = 1;
         1: if (!en) mstate = 0; else if (lvl >= PL) mstate = 2;
         default: if (!en) begin mstate = 0; if (MID_EN) msample = MID; end
      endcase
      mcnt = (old_state == 2 && en) ? (mcnt + 1) % RD : 0;
      marmed = 1;
   endtask

   // one clock of stimulus; outputs are checked 2 time units after the edge
   task automatic drive(input bit r, input bit en, input bit v, input int d, input bit clr);
      reset = r; enable = en; in_valid = v; in_data = DW'(d); clear_underflow = clr;
      model_step(r, en, v, d, clr);
      if (!r) begin
         #1;
         chk("reset_level", int'(level), 0);
         chk("reset_in_ready", int'(in_ready), 0);
         chk("reset_sample_out", int'(sample_out), RST_VAL);
         chk("reset_underflow", int'(underflow), 0);
      end
      @(posedge clk);
      #2;
      chk("level", int'(level), mq.size());
      chk("in_ready", int'(in_ready), int'(marmed && mq.size() != DEPTH));
      chk("underflow", int'(underflow), int'(munder));
      chk("sample_out", int'(sample_out), msample);
      chk("sample_strobe", int'(sample_strobe), int'(mstrobe));
   endtask

   task automatic idle_cycles(input bit en, input int n);
      for (int i = 0; i < n; i++) drive(1, en, 0, 0, 0);
   endtask

   initial begin
      int guard;
      @(posedge clk); #2;
      // reset and release
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      // reset mid-stream with five buffered samples
      for (int i = 0; i < 5; i++) drive(1, 0, 1, $urandom_range(255), 0);
      chk("level_before_reset", int'(level), 5);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      // priming then paced output of 0x10..0x17, draining into underflow
      for (int i = 0; i < 8; i++) drive(1, 1, 1, 'h10 + i, 0);
      idle_cycles(1, 44);
      // clear pulses, some coinciding with empty ticks
      for (int i = 0; i < 12; i++) drive(1, 1, 0, 0, 1);
      drive(1, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 1);
      // backpressure: 20 pushes with valid held while disabled
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) drive(1, 0, 1, $urandom_range(255), 0);
      chk("full_level", int'(level), DEPTH);
      for (int i = 0; i < 40; i++) drive(1, 1, 1, $urandom_range(255), 0);
      // drain to about six, disable, then re-enable with fresh pushes
      guard = 0;
      while (mq.size() > 6 && guard < 200) begin drive(1, 1, 0, 0, 0); guard++; end
      chk("drain_guard", int'(guard < 200), 1);
      idle_cycles(0, 10);
      for (int i = 0; i < 30; i++) drive(1, 1, ($urandom_range(3) == 0), $urandom_range(255), 0);
      // matched rate around level three
      guard = 0;
      while (mq.size() > 3 && guard < 200) begin drive(1, 1, 0, 0, 0); guard++; end
      chk("match_guard", int'(guard < 200), 1);
      for (int i = 0; i < 400; i++) drive(1, 1, (i % RD == 0), $urandom_range(255), 0);
      // random traffic with occasional disables, clears and resets
      for (int i = 0; i < 3000; i++)
         drive(($urandom_range(499) != 0), ($urandom_range(15) != 0),
               ($urandom_range(3) == 0), $urandom_range(255), ($urandom_range(9) == 0));
      chk("scoreboard_drained", expq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dac_sample_feeder.md
Name: dac_sample_feeder

Overview:
- Rate-pacing sample buffer directly upstream of the sigma-delta DAC top. Its sample_out drives the DAC's 8-bit dataIn.
- Accepts bursty unsigned (offset-binary) samples over a valid/ready interface into a small FIFO.
- Releases one sample every RATE_DIV clocks, so the interpolating filter sees a steady sample rate.
- Handles priming, underflow and enable/disable cleanly.

Parameters:
DATA_W, 8, sample width; unsigned offset-binary.
DEPTH, 16, FIFO entries; power of two, minimum 4.
RATE_DIV, 64, clocks per output sample; minimum 2.
PRIME_LEVEL, 8, FIFO level required before output starts; 1..DEPTH.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset: 0 = reset asserted, asynchronous assert, synchronous release to clk.
enable  in  1  1 = run the pacer; 0 = park in IDLE.
in_data  in  DATA_W  input sample.
in_valid  in  1  in_data is valid.
in_ready  out  1  FIFO can accept; equals !full.
sample_out  out  DATA_W  registered sample presented to the DAC.
sample_strobe  out  1  one-cycle pulse on the cycle sample_out takes a new value.
level  out  $clog2(DEPTH)+1  current FIFO occupancy, registered.
underflow  out  1  sticky: a tick found the FIFO empty while in RUN.
clear_underflow  in  1  synchronous clear of underflow.

Behaviour:
- Reset (reset=0) values: sample_out=0, sample_strobe=0, underflow=0, level=0, in_ready=0, FSM=IDLE, pacer=0, FIFO pointers=0.
- in_ready goes to 1 on the first clk after reset release.
- Push: when in_valid && in_ready. Independent of FSM state, so the FIFO may fill while IDLE/PRIME.
- in_ready = (level != DEPTH), from the registered level. A push and a pop in the same cycle when full: push is still refused.
- Pacer counter:
  - Counts 0..RATE_DIV-1 and wraps only while the FSM is in RUN. Held at 0 in IDLE/PRIME.
  - tick = RUN && counter==RATE_DIV-1.
- FSM:
  - IDLE: enable=1 -> PRIME.
  - PRIME: enable=0 -> IDLE; else level >= PRIME_LEVEL -> RUN.
  - RUN: enable=0 -> IDLE (pacer cleared, FIFO contents retained, sample_out held). Otherwise stays in RUN.
- On tick, FIFO non-empty (registered level>0):
  - Pop the head.
  - sample_out <= head and sample_strobe=1 on the same edge.
  - Output latency is one clock from the tick cycle.
- On tick, FIFO empty:
  - No pop; underflow <= 1; sample_out keeps its previous value (see Optional Feature); sample_strobe=1.
  - FSM stays in RUN, so the DAC keeps a constant rate with no re-prime.
- A push arriving in the same cycle as an empty-FIFO tick is stored and counted as an underflow for that tick; it pops on the next tick.
- Level update: level += push - pop each cycle. Simultaneous push+pop with 0 < level < DEPTH leaves level unchanged.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- underflow:
  - clear_underflow=1 clears it.
  - If clear_underflow and a new underflow coincide, the set wins (underflow=1).
- sample_strobe is low in every cycle except the tick+1 edge result; never high in IDLE/PRIME.
- Reset asserted mid-operation: every output immediately returns to its reset value; FIFO contents are discarded.

Optional Feature:
- Macro: DAC_FEEDER_MIDSCALE_EN.
- Defined:
  - An underflow tick loads sample_out with midscale 1<<(DATA_W-1), i.e. 0x80 for 8 bits, instead of holding.
  - The reset value of sample_out is also midscale.
  - Entering IDLE from RUN loads midscale, silencing the DAC output at DC-centre.
- Undefined: hold-last-sample behaviour as above; reset value 0.

Decomposition:
- Shared package dac_pkg:
  - FSM state enum: IDLE, PRIME, RUN.
  - Function for midscale value of a given width.
  - Default DATA_W constant shared with the DAC top.
- One natural sub-module: dac_sample_fifo.
  - Synchronous FWFT-style register FIFO with push/pop/level/full/empty.
  - Same asynchronous active-low reset.
- Pacer and FSM stay in the top of dac_sample_feeder.

Test Plan:
- Reset check: hold reset=0 mid-stream with level=5 -> level=0, sample_out=0 (0x80 with macro), in_ready=0 during reset, 1 one cycle after release.
- Prime/start (RATE_DIV=4, PRIME_LEVEL=8): enable=1, push 0x10..0x17 -> no strobe until level reaches 8. Strobes then occur exactly every 4 clocks with values 0x10, 0x11, ... in order.
- Full/backpressure: enable=0, push 20 samples with in_valid held -> in_ready=0 after 16 accepted, level=16. Samples 17..20 are not accepted until pops occur.
- Underflow: RUN with 2 samples 0xA0, 0xA1 and no further pushes -> strobes emit 0xA0, 0xA1, then 0xA1 held (0x80 with macro) and underflow=1. A clear_underflow pulse coinciding with the next empty tick leaves underflow=1.
- Disable mid-run: enable=0 with level=6 -> IDLE, no strobes, level stays 6. Re-enable -> PRIME passes only once level >= PRIME_LEVEL; the first strobe delivers the oldest retained sample.
- Simultaneous push/pop at level=3 over 100 ticks at matched rate -> level constant 3, no underflow, output order equals input order.
